// File: rtl/ipsmacge_txseq_if.sv
// Byte-wide frame stream handshake feeding ipsmacge_txseq (fvld/frdy transfer, sop/eop/err sideband).
interface ipsmacge_txseq_if #(
    parameter int DAT_DW = 8
) ();
    logic [DAT_DW-1:0] fdat;
    logic              fvld;
    logic              fsop;
    logic              feop;
    logic              ferr;
    logic              frdy;

    modport master (output fdat, fvld, fsop, feop, ferr, input frdy);
    modport slave  (input fdat, fvld, fsop, feop, ferr, output frdy);
endinterface

// File: rtl/ipsmacge_txseq.sv
// Tx frame sequencer: preamble/SFD insertion, byte pacing per speed, underrun handling, IPG.
// Optional IPSMACGE_TXSEQ_STAT_EN adds stat_frm/stat_urun frame and underrun counters.
module ipsmacge_txseq #(
    parameter int DAT_DW  = 8,
    parameter int MSP_DW  = 2,
    parameter int PRE_LEN = 7,
    parameter int IPG_LEN = 12,
    parameter int CNT_DW  = 4
) (
    input  logic              txclk,
    input  logic              txrst_,
    ipsmacge_txseq_if.slave   fif,
    output logic [DAT_DW-1:0] igdat,
    output logic              igval,
    output logic              igen,
    output logic              iger,
    input  logic              up_act,
    input  logic              up_gmii,
    input  logic [MSP_DW-1:0] up_spd,
    output logic              busy
`ifdef IPSMACGE_TXSEQ_STAT_EN
    ,
    output logic [15:0]       stat_frm,
    output logic [7:0]        stat_urun
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_URUN = 3'd4;
    localparam logic [2:0] ST_IPG  = 3'd5;

    localparam logic [MSP_DW-1:0] SPD_RSV = MSP_DW'(2'b11);
    localparam logic [MSP_DW-1:0] SPD_1G  = MSP_DW'(2'b10);
    localparam logic [CNT_DW-1:0] PRE_LAST = CNT_DW'(PRE_LEN - 1);
    localparam logic [CNT_DW-1:0] IPG_LAST = CNT_DW'(IPG_LEN - 1);

    logic [2:0]        st, nst;
    logic [CNT_DW-1:0] cnt, ncnt;
    logic              ph, nph;
    logic              gig, ngig;
    logic [DAT_DW-1:0] h_dat, nh_dat;
    logic              h_err, nh_err, h_eop, nh_eop;
    logic              frdy_q;
    logic              slot_end, accept, start, dis;
    logic [DAT_DW-1:0] igdat_n;
    logic              igval_n, igen_n, iger_n, frdy_n, busy_n;
    logic              unused_gmii;

    assign unused_gmii = up_gmii;
    assign fif.frdy    = frdy_q;

    assign slot_end = gig | ph;
    assign accept   = frdy_q & fif.fvld;
    assign start    = fif.fvld & fif.fsop & up_act & (up_spd != SPD_RSV);
    assign dis      = ~up_act | (up_spd == SPD_RSV);

    always_comb begin
        nst    = st;
        ncnt   = cnt;
        ngig   = gig;
        nh_dat = accept ? fif.fdat : h_dat;
        nh_err = accept ? fif.ferr : h_err;
        nh_eop = accept ? fif.feop : h_eop;
        case (st)
            ST_IDLE: if (start) begin
                nst  = ST_PRE;
                ncnt = '0;
                ngig = (up_spd == SPD_1G);
            end
            ST_PRE: if (slot_end) begin
                if (cnt == PRE_LAST) begin
                    nst  = ST_SFD;
                    ncnt = '0;
                end else begin
                    ncnt = cnt + 1'b1;
                end
            end
            ST_SFD, ST_DATA: if (slot_end) begin
                if (st == ST_DATA && h_eop) begin
                    nst  = ST_IPG;
                    ncnt = '0;
                end else if (accept) begin
                    nst = ST_DATA;
                end else begin
                    nst = ST_URUN;
                end
            end
            ST_URUN: if (slot_end) begin
                nst  = ST_IPG;
                ncnt = '0;
            end
            ST_IPG: if (slot_end) begin
                ncnt = '0;
                // A pending frame starts straight out of the last gap slot, so the gap is exactly IPG_LEN
                if (cnt != IPG_LAST) begin
                    ncnt = cnt + 1'b1;
                end else if (start) begin
                    nst  = ST_PRE;
                    ngig = (up_spd == SPD_1G);
                end else begin
                    nst = ST_IDLE;
                end
            end
            default: nst = ST_IDLE;
        endcase
        if (dis) begin
            nst    = ST_IDLE;
            ncnt   = '0;
            ngig   = 1'b0;
            nh_dat = '0;
            nh_err = 1'b0;
            nh_eop = 1'b0;
        end

        nph = (nst == ST_IDLE || ngig || (nst == ST_PRE && st != ST_PRE)) ? 1'b0 : ~ph;

        igen_n = (nst inside {ST_PRE, ST_SFD, ST_DATA, ST_URUN});
        case (nst)
            ST_PRE:  igdat_n = DAT_DW'(8'h55);
            ST_SFD:  igdat_n = DAT_DW'(8'hD5);
            ST_DATA: igdat_n = nh_dat;
            default: igdat_n = '0;
        endcase
        iger_n  = (nst == ST_DATA && nh_err) || (nst == ST_URUN);
        igval_n = (nst != ST_IDLE) && !nph;
        frdy_n  = (nst == ST_SFD || (nst == ST_DATA && !nh_eop)) && (ngig || nph);
        busy_n  = (nst != ST_IDLE);
    end

    always_ff @(posedge txclk or negedge txrst_) begin
        if (!txrst_) begin
            st     <= ST_IDLE;
            cnt    <= '0;
            ph     <= 1'b0;
            gig    <= 1'b0;
            h_dat  <= '0;
            h_err  <= 1'b0;
            h_eop  <= 1'b0;
            igdat  <= '0;
            igval  <= 1'b0;
            igen   <= 1'b0;
            iger   <= 1'b0;
            frdy_q <= 1'b0;
            busy   <= 1'b0;
        end else begin
            st     <= nst;
            cnt    <= ncnt;
            ph     <= nph;
            gig    <= ngig;
            h_dat  <= nh_dat;
            h_err  <= nh_err;
            h_eop  <= nh_eop;
            igdat  <= igdat_n;
            igval  <= igval_n;
            igen   <= igen_n;
            iger   <= iger_n;
            frdy_q <= frdy_n;
            busy   <= busy_n;
        end
    end

`ifdef IPSMACGE_TXSEQ_STAT_EN
    logic frm_done, urun_hit;

    assign frm_done = (st == ST_DATA) && slot_end && h_eop && !dis;
    assign urun_hit = (nst == ST_URUN) && (st != ST_URUN);

    always_ff @(posedge txclk or negedge txrst_) begin
        if (!txrst_) begin
            stat_frm  <= '0;
            stat_urun <= '0;
        end else begin
            if (frm_done) stat_frm  <= stat_frm + 16'd1;
            if (urun_hit) stat_urun <= stat_urun + 8'd1;
        end
    end
`endif

endmodule
